regfile_px: RTL and testbench

REGFILE_PX -- requirements
Module: regfile_px

---
 rtl/regfile_px.sv | 128 ++++++++++++
 tb/tb_regfile_px.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_px.sv
// Dual-write, dual-read register file with per-register pending flags,
// optional write-to-read forwarding and a sequential scrub that zeroes every entry.
module regfile_px #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] qa0,
  output logic [DW-1:0] qa1,
  output logic          pa0,
  output logic          pa1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] wn0,
  input  logic [AW-1:0] wn1,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic          pset,
  input  logic [AW-1:0] pwn,
  input  logic          scrub_req,
  output logic          scrub_busy
);

  localparam int N = 1 << AW;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic [DW-1:0] r_regs [N];
  logic [N-1:0]  r_pend;

  logic w_scrub;
  logic w_we0;
  logic w_we1;
  logic w_pset;
  logic w_byp;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualified requests: nothing from the ports lands while scrubbing, and the
  // hardwired zero register never accepts data or a producer mark.
  assign w_scrub = (r_state == SCRUB);
  assign w_we0   = we0  && !w_scrub && !is_zero(wn0);
  assign w_we1   = we1  && !w_scrub && !is_zero(wn1);
  assign w_pset  = pset && !w_scrub && !is_zero(pwn);
  assign w_byp   = (BYPASS != 0) && !w_scrub;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (scrub_req) begin
          w_state_nxt = SCRUB;
          w_idx_nxt   = '0;
        end
      end
      SCRUB: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == {AW{1'b1}}) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int k = 0; k < N; k++) r_regs[k] <= '0;
    end else if (w_scrub) begin
      r_regs[r_idx] <= '0;
    end else begin
      if (w_we0) r_regs[wn0] <= d0;
      if (w_we1) r_regs[wn1] <= d1;
    end
  end

  // A new producer mark overrides a completing write to the same register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_pend <= '0;
    end else if (w_scrub) begin
      r_pend[r_idx] <= 1'b0;
    end else begin
      if (w_we0)  r_pend[wn0] <= 1'b0;
      if (w_we1)  r_pend[wn1] <= 1'b0;
      if (w_pset) r_pend[pwn] <= 1'b1;
    end
  end

  assign qa0 = is_zero(ra0)                   ? '0 :
               (w_byp && w_we1 && wn1 == ra0) ? d1 :
               (w_byp && w_we0 && wn0 == ra0) ? d0 : r_regs[ra0];
  assign qa1 = is_zero(ra1)                   ? '0 :
               (w_byp && w_we1 && wn1 == ra1) ? d1 :
               (w_byp && w_we0 && wn0 == ra1) ? d0 : r_regs[ra1];

  assign pa0        = !is_zero(ra0) && r_pend[ra0];
  assign pa1        = !is_zero(ra1) && r_pend[ra1];
  assign scrub_busy = w_scrub;

endmodule

// File: tb/tb_regfile_px.sv
// Directed bench for regfile_px: reset, forwarding, zero register, pending flags,
// scrub sequencing and reset during scrub.
module tb_regfile_px;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          clrn;
  logic [AW-1:0] ra0, ra1, wn0, wn1, pwn;
  logic [DW-1:0] d0, d1, qa0, qa1;
  logic          pa0, pa1, we0, we1, pset, scrub_req, scrub_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_px #(.DW(DW), .AW(AW), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .clrn(clrn),
    .ra0(ra0), .ra1(ra1), .qa0(qa0), .qa1(qa1), .pa0(pa0), .pa1(pa1),
    .we0(we0), .we1(we1), .wn0(wn0), .wn1(wn1), .d0(d0), .d1(d1),
    .pset(pset), .pwn(pwn), .scrub_req(scrub_req), .scrub_busy(scrub_busy)
  );

  task automatic quiet();
    we0 = 1'b0; we1 = 1'b0; pset = 1'b0; scrub_req = 1'b0;
  endtask

  // Writes 0x1000_0000|k into registers lo..hi, one per cycle through port 0.
  task automatic fill(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      we0 = 1'b1; wn0 = AW'(k); d0 = 32'h1000_0000 | DW'(k);
    end
    @(negedge clk);
    we0 = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; quiet();
    ra0 = 5'd3; ra1 = 5'd31; wn0 = '0; wn1 = '0; pwn = '0; d0 = '0; d1 = '0;
    #12;
    total++; if (qa0 !== 32'h0) begin bad++; $display("FAIL reset_qa0 got=%h exp=%h", qa0, 32'h0); end
    total++; if (qa1 !== 32'h0) begin bad++; $display("FAIL reset_qa1 got=%h exp=%h", qa1, 32'h0); end
    total++; if (pa0 !== 1'b0) begin bad++; $display("FAIL reset_pa0 got=%b exp=0", pa0); end
    total++; if (pa1 !== 1'b0) begin bad++; $display("FAIL reset_pa1 got=%b exp=0", pa1); end
    total++; if (scrub_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", scrub_busy); end
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we0 = 1'b1; wn0 = 5'd5; d0 = 32'hAAAA_0000;
    we1 = 1'b1; wn1 = 5'd5; d1 = 32'h1234_5678;
    ra0 = 5'd5;
    #1;
    total++; if (qa0 !== 32'h1234_5678) begin bad++; $display("FAIL byp_same_cycle got=%h exp=%h", qa0, 32'h1234_5678); end
    @(posedge clk); #1;
    quiet(); #1;
    total++; if (qa0 !== 32'h1234_5678) begin bad++; $display("FAIL byp_stored got=%h exp=%h", qa0, 32'h1234_5678); end
    @(negedge clk);
    we0 = 1'b1; wn0 = 5'd6; d0 = 32'h0BAD_F00D; ra1 = 5'd6;
    #1;
    total++; if (qa1 !== 32'h0BAD_F00D) begin bad++; $display("FAIL byp_port0 got=%h exp=%h", qa1, 32'h0BAD_F00D); end
    total++; if (qa0 !== 32'h1234_5678) begin bad++; $display("FAIL byp_other_addr got=%h exp=%h", qa0, 32'h1234_5678); end
    @(posedge clk); #1;
    quiet(); #1;
    total++; if (qa1 !== 32'h0BAD_F00D) begin bad++; $display("FAIL byp_port0_stored got=%h exp=%h", qa1, 32'h0BAD_F00D); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    we0 = 1'b1; wn0 = 5'd0; d0 = 32'hFFFF_FFFF; ra1 = 5'd0;
    pset = 1'b1; pwn = 5'd0;
    #1;
    total++; if (qa1 !== 32'h0) begin bad++; $display("FAIL zero_before got=%h exp=%h", qa1, 32'h0); end
    @(posedge clk); #1;
    quiet(); #1;
    total++; if (qa1 !== 32'h0) begin bad++; $display("FAIL zero_after got=%h exp=%h", qa1, 32'h0); end
    total++; if (pa1 !== 1'b0) begin bad++; $display("FAIL zero_pend got=%b exp=0", pa1); end
  endtask

  task automatic test_pending();
    @(negedge clk);
    pset = 1'b1; pwn = 5'd7; ra0 = 5'd7;
    #1;
    total++; if (pa0 !== 1'b0) begin bad++; $display("FAIL pend_no_bypass got=%b exp=0", pa0); end
    @(posedge clk); #1;
    quiet(); #1;
    total++; if (pa0 !== 1'b1) begin bad++; $display("FAIL pend_set got=%b exp=1", pa0); end
    @(negedge clk);
    we1 = 1'b1; wn1 = 5'd7; d1 = 32'h7777_0001; pset = 1'b1; pwn = 5'd7;
    @(posedge clk); #1;
    quiet(); #1;
    total++; if (pa0 !== 1'b1) begin bad++; $display("FAIL pend_set_wins got=%b exp=1", pa0); end
    total++; if (qa0 !== 32'h7777_0001) begin bad++; $display("FAIL pend_write_data got=%h exp=%h", qa0, 32'h7777_0001); end
    @(negedge clk);
    we0 = 1'b1; wn0 = 5'd7; d0 = 32'h7777_0002;
    #1;
    total++; if (pa0 !== 1'b1) begin bad++; $display("FAIL pend_clear_early got=%b exp=1", pa0); end
    @(posedge clk); #1;
    quiet(); #1;
    total++; if (pa0 !== 1'b0) begin bad++; $display("FAIL pend_clear got=%b exp=0", pa0); end
  endtask

  task automatic test_scrub();
    int cnt;
    fill(1, N - 1);
    @(negedge clk);
    pset = 1'b1; pwn = 5'd30; ra0 = 5'd9; ra1 = 5'd30;
    @(negedge clk);
    quiet(); #1;
    total++; if (qa0 !== 32'h1000_0009) begin bad++; $display("FAIL scrub_prefill got=%h exp=%h", qa0, 32'h1000_0009); end
    total++; if (pa1 !== 1'b1) begin bad++; $display("FAIL scrub_prepend got=%b exp=1", pa1); end
    scrub_req = 1'b1;
    @(posedge clk); #1;
    scrub_req = 1'b0;
    cnt = scrub_busy ? 1 : 0;
    total++; if (cnt !== 1) begin bad++; $display("FAIL scrub_start busy=%b exp=1", scrub_busy); end
    while (scrub_busy && cnt < 100) begin
      if (cnt == 5) begin
        we0 = 1'b1; wn0 = 5'd9; d0 = 32'hDEAD_0009;
        we1 = 1'b1; wn1 = 5'd2; d1 = 32'hDEAD_0002;
        pset = 1'b1; pwn = 5'd3; ra0 = 5'd9; ra1 = 5'd1;
        #1;
        total++; if (qa0 !== 32'h1000_0009) begin bad++; $display("FAIL scrub_no_bypass got=%h exp=%h", qa0, 32'h1000_0009); end
        total++; if (qa1 !== 32'h0) begin bad++; $display("FAIL scrub_partial got=%h exp=%h", qa1, 32'h0); end
      end else begin
        quiet();
      end
      @(posedge clk); #1;
      if (scrub_busy) cnt++;
    end
    quiet();
    total++; if (cnt !== N) begin bad++; $display("FAIL scrub_cycles got=%0d exp=%0d", cnt, N); end
    for (int k = 0; k < N; k += 2) begin
      ra0 = AW'(k); ra1 = AW'(k + 1);
      #1;
      total++; if (qa0 !== 32'h0 || qa1 !== 32'h0) begin
        bad++; $display("FAIL scrub_clear r%0d=%h r%0d=%h exp=0", k, qa0, k + 1, qa1);
      end
      total++; if (pa0 !== 1'b0 || pa1 !== 1'b0) begin
        bad++; $display("FAIL scrub_pend r%0d=%b r%0d=%b exp=0", k, pa0, k + 1, pa1);
      end
    end
  endtask

  task automatic test_reset_mid_scrub();
    int cnt;
    fill(20, 20);
    @(negedge clk);
    pset = 1'b1; pwn = 5'd25;
    @(negedge clk);
    quiet(); ra0 = 5'd20; ra1 = 5'd25;
    scrub_req = 1'b1;
    @(posedge clk); #1;
    scrub_req = 1'b0;
    cnt = 1;
    while (cnt < 10 && scrub_busy) begin
      @(posedge clk); #1;
      if (scrub_busy) cnt++;
    end
    total++; if (cnt !== 10) begin bad++; $display("FAIL rst_scrub_reach got=%0d exp=10", cnt); end
    total++; if (qa0 !== 32'h1000_0014) begin bad++; $display("FAIL rst_scrub_pre got=%h exp=%h", qa0, 32'h1000_0014); end
    clrn = 1'b0;
    #1;
    total++; if (scrub_busy !== 1'b0) begin bad++; $display("FAIL rst_scrub_busy got=%b exp=0", scrub_busy); end
    total++; if (qa0 !== 32'h0) begin bad++; $display("FAIL rst_scrub_reg got=%h exp=%h", qa0, 32'h0); end
    total++; if (pa1 !== 1'b0) begin bad++; $display("FAIL rst_scrub_pend got=%b exp=0", pa1); end
    @(negedge clk);
    clrn = 1'b1;
    we0 = 1'b1; wn0 = 5'd12; d0 = 32'hCAFE_BABE;
    @(posedge clk); #1;
    quiet(); ra0 = 5'd12; #1;
    total++; if (qa0 !== 32'hCAFE_BABE) begin bad++; $display("FAIL rst_scrub_write got=%h exp=%h", qa0, 32'hCAFE_BABE); end
    total++; if (scrub_busy !== 1'b0) begin bad++; $display("FAIL rst_scrub_idle got=%b exp=0", scrub_busy); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_pending();
    test_scrub();
    test_reset_mid_scrub();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
